// File: rtl/regset_frontend_pkg.sv
// -----------------------------------------------------------------------------
// regset_frontend_pkg
// Shared definitions for the register-set front end: array geometry, the
// CLEAR/RUN state encoding and the 33-bit operand record {grubby, data}.
// -----------------------------------------------------------------------------
package regset_frontend_pkg;

    localparam int REGSET_AW = 6;
    localparam int REGSET_N  = 64;
    localparam int OPERAND_W = 33;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } regset_state_e;

    typedef struct packed {
        logic        grubby;
        logic [31:0] data;
    } operand_t;

endpackage

// File: rtl/regset_bypass_port.sv
// -----------------------------------------------------------------------------
// regset_bypass_port
// One read port of the register-set front end.
//   - Chooses the effective read address (held address during a stall).
//   - Remembers whether the write issued in the same cycle targets that
//     address, because the read-first BRAM would return the old contents.
//   - Muxes bypassed write data or BRAM data onto the operand output, and
//     forces the operand to zero until the array has been cleared.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   run                 front end is in RUN (bypass allowed)
//   ready               array cleared; operand output enabled
//   rd_hold, rd_addr    stall request and requested read address
//   wr_we, wr_addr      write strobe/address actually sent to the BRAM
//   wr_data, wr_grubby  pipeline writeback payload
//   rs_rd, rs_rg        BRAM read data (one cycle after ea)
//   ea                  effective read address, drives the BRAM read port
//   op                  corrected operand
// -----------------------------------------------------------------------------
module regset_bypass_port
    import regset_frontend_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 ready,
    input  logic                 rd_hold,
    input  logic [REGSET_AW-1:0] rd_addr,
    input  logic                 wr_we,
    input  logic [REGSET_AW-1:0] wr_addr,
    input  logic [31:0]          wr_data,
    input  logic                 wr_grubby,
    input  logic [31:0]          rs_rd,
    input  logic                 rs_rg,
    output logic [REGSET_AW-1:0] ea,
    output operand_t             op
);

    logic [REGSET_AW-1:0] lat_addr_r;
    logic                 byp_r;
    operand_t             bypdata_r;

    // Effective address: during a stall re-present the last address used.
    always_comb begin
        ea = rd_addr;
        if (rd_hold) begin
            ea = lat_addr_r;
        end else begin
            ea = rd_addr;
        end
    end

    // Latch the effective address and capture a same-cycle write hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr_r <= {REGSET_AW{1'b0}};
            byp_r      <= 1'b0;
            bypdata_r  <= '0;
        end else begin
            lat_addr_r <= ea;
            // wr_we is already suppressed for entry 0, so x0 never bypasses.
            byp_r      <= wr_we && (wr_addr == ea) && run;
            bypdata_r  <= '{grubby: wr_grubby, data: wr_data};
        end
    end

    // Operand mux: zero until ready, else bypassed data or BRAM data.
    always_comb begin
        op = '0;
        if (!ready) begin
            op = '0;
        end else if (byp_r) begin
            op = bypdata_r;
        end else begin
            op = '{grubby: rs_rg, data: rs_rd};
        end
    end

endmodule

// File: rtl/regset_frontend.sv
// -----------------------------------------------------------------------------
// regset_frontend
// Owns the write and both read ports of the 64-entry register-set BRAM.
//   - After reset, sweeps zeros (data and grubby) into the array so that
//     register sets without BRAM preinit start out clean; ready rises the
//     cycle after the last clear write.
//   - In RUN, forwards pipeline writebacks except writes to entry 0.
//   - Two regset_bypass_port instances supply stall-stable read addresses
//     and same-cycle write bypass for the two operands.
// Parameters:
//   CLEAR_ALL  1: clear all entries (64 cycles); 0: clear entry 0 only
//   NREGS      number of entries, must be 64 (6-bit addresses)
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data/wr_grubby  pipeline writeback
//   rd_addr1/rd_addr2, rd_hold       operand addresses and stall
//   ready                            array cleared and usable
//   op1/op1_grubby, op2/op2_grubby   corrected operands
//   rs_*                             BRAM write/read port connections
// -----------------------------------------------------------------------------
module regset_frontend
    import regset_frontend_pkg::*;
#(
    parameter int CLEAR_ALL = 1,
    parameter int NREGS     = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [REGSET_AW-1:0] wr_addr,
    input  logic [31:0]          wr_data,
    input  logic                 wr_grubby,
    input  logic [REGSET_AW-1:0] rd_addr1,
    input  logic [REGSET_AW-1:0] rd_addr2,
    input  logic                 rd_hold,
    output logic                 ready,
    output logic [31:0]          op1,
    output logic                 op1_grubby,
    output logic [31:0]          op2,
    output logic                 op2_grubby,
    output logic                 rs_we,
    output logic [REGSET_AW-1:0] rs_wa,
    output logic [31:0]          rs_wd,
    output logic                 rs_wg,
    output logic [REGSET_AW-1:0] rs_ra1,
    output logic [REGSET_AW-1:0] rs_ra2,
    input  logic [31:0]          rs_rd1,
    input  logic                 rs_rg1,
    input  logic [31:0]          rs_rd2,
    input  logic                 rs_rg2
);

    // Index of the final clear write for the selected sweep mode.
    localparam logic [REGSET_AW-1:0] CLEAR_LAST =
        (CLEAR_ALL != 0) ? REGSET_AW'(NREGS - 1) : {REGSET_AW{1'b0}};

    regset_state_e        state_r;
    regset_state_e        state_nxt_s;
    logic [REGSET_AW-1:0] cnt_r;
    logic [REGSET_AW-1:0] cnt_nxt_s;
    logic                 ready_r;
    logic                 ready_nxt_s;
    logic                 run_s;
    operand_t             op1_s;
    operand_t             op2_s;

    // State, clear counter and ready registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_CLEAR;
            cnt_r   <= {REGSET_AW{1'b0}};
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ready_r <= ready_nxt_s;
        end
    end

    // Next-state logic: step the sweep, leave CLEAR after the last write.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ready_nxt_s = ready_r;
        case (state_r)
            ST_CLEAR: begin
                if (cnt_r == CLEAR_LAST) begin
                    state_nxt_s = ST_RUN;
                    ready_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + {{(REGSET_AW-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                ready_nxt_s = 1'b1;
            end
            default: begin
                state_nxt_s = ST_CLEAR;
                cnt_nxt_s   = {REGSET_AW{1'b0}};
                ready_nxt_s = 1'b0;
            end
        endcase
    end

    // BRAM write port: sweep zeros in CLEAR, filtered writeback in RUN.
    always_comb begin
        rs_we = 1'b0;
        rs_wa = {REGSET_AW{1'b0}};
        rs_wd = 32'd0;
        rs_wg = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                rs_we = 1'b1;
                rs_wa = cnt_r;
            end
            ST_RUN: begin
                rs_we = wr_en && (wr_addr != {REGSET_AW{1'b0}});
                rs_wa = wr_addr;
                rs_wd = wr_data;
                rs_wg = wr_grubby;
            end
            default: begin
                rs_we = 1'b0;
            end
        endcase
    end

    assign run_s = (state_r == ST_RUN);
    assign ready = ready_r;

    regset_bypass_port u_port1 (
        .clk       (clk),
        .rst       (rst),
        .run       (run_s),
        .ready     (ready_r),
        .rd_hold   (rd_hold),
        .rd_addr   (rd_addr1),
        .wr_we     (rs_we),
        .wr_addr   (rs_wa),
        .wr_data   (wr_data),
        .wr_grubby (wr_grubby),
        .rs_rd     (rs_rd1),
        .rs_rg     (rs_rg1),
        .ea        (rs_ra1),
        .op        (op1_s)
    );

    regset_bypass_port u_port2 (
        .clk       (clk),
        .rst       (rst),
        .run       (run_s),
        .ready     (ready_r),
        .rd_hold   (rd_hold),
        .rd_addr   (rd_addr2),
        .wr_we     (rs_we),
        .wr_addr   (rs_wa),
        .wr_data   (wr_data),
        .wr_grubby (wr_grubby),
        .rs_rd     (rs_rd2),
        .rs_rg     (rs_rg2),
        .ea        (rs_ra2),
        .op        (op2_s)
    );

    assign op1        = op1_s.data;
    assign op1_grubby = op1_s.grubby;
    assign op2        = op2_s.data;
    assign op2_grubby = op2_s.grubby;

endmodule

// File: tb/tb_regset_frontend.sv
// -----------------------------------------------------------------------------
// tb_regset_frontend
// Drives regset_frontend (CLEAR_ALL=1) with directed and random traffic
// against a register-file model plus a BRAM model, and a second instance
// (CLEAR_ALL=0) checked against a tiny sweep model.
// -----------------------------------------------------------------------------
module tb_regset_frontend;

    localparam int SEL_OP1 = 0;
    localparam int SEL_OP2 = 1;
    localparam int SEL_RA1 = 2;
    localparam int SEL_WA  = 3;
    localparam int SEL_RDY = 4;
    localparam int SEL_WE  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT signals
    logic        rst, wr_en, wr_grubby, rd_hold;
    logic [5:0]  wr_addr, rd_addr1, rd_addr2;
    logic [31:0] wr_data;
    logic        ready, op1_grubby, op2_grubby, rs_we, rs_wg, rs_rg1, rs_rg2;
    logic [31:0] op1, op2, rs_wd, rs_rd1, rs_rd2;
    logic [5:0]  rs_wa, rs_ra1, rs_ra2;

    // CLEAR_ALL=0 DUT signals
    logic        rst0, ready0, o1g0, o2g0, we0, wg0;
    logic [31:0] o1_0, o2_0, wd0;
    logic [5:0]  wa0, ra1_0, ra2_0;

    regset_frontend #(.CLEAR_ALL(1), .NREGS(64)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_grubby(wr_grubby), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_hold(rd_hold),
        .ready(ready), .op1(op1), .op1_grubby(op1_grubby), .op2(op2), .op2_grubby(op2_grubby),
        .rs_we(rs_we), .rs_wa(rs_wa), .rs_wd(rs_wd), .rs_wg(rs_wg), .rs_ra1(rs_ra1),
        .rs_ra2(rs_ra2), .rs_rd1(rs_rd1), .rs_rg1(rs_rg1), .rs_rd2(rs_rd2), .rs_rg2(rs_rg2)
    );

    regset_frontend #(.CLEAR_ALL(0), .NREGS(64)) dut0 (
        .clk(clk), .rst(rst0), .wr_en(1'b1), .wr_addr(6'd9), .wr_data(32'hCAFE0009),
        .wr_grubby(1'b1), .rd_addr1(6'd0), .rd_addr2(6'd0), .rd_hold(1'b0),
        .ready(ready0), .op1(o1_0), .op1_grubby(o1g0), .op2(o2_0), .op2_grubby(o2g0),
        .rs_we(we0), .rs_wa(wa0), .rs_wd(wd0), .rs_wg(wg0), .rs_ra1(ra1_0),
        .rs_ra2(ra2_0), .rs_rd1(32'd0), .rs_rg1(1'b0), .rs_rd2(32'd0), .rs_rg2(1'b0)
    );

    // BRAM model: read-first, one-cycle read latency, garbage power-up contents
    logic [32:0] garb [64];
    logic [32:0] bram [64];
    logic        fill_en;
    always @(posedge clk) begin
        {rs_rg1, rs_rd1} <= bram[rs_ra1];
        {rs_rg2, rs_rd2} <= bram[rs_ra2];
        if (fill_en) begin
            for (int i = 0; i < 64; i++) bram[i] <= garb[i];
        end else if (rs_we) begin
            bram[rs_wa] <= {rs_wg, rs_wd};
        end
    end

    // directed literal expectations, two slots per cycle
    logic        dir_en  [2];
    int          dir_sel [2];
    logic [32:0] dir_val [2];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // reference model state (owned by the compare process only)
    logic        mdl_en = 1'b0;
    logic        mdl_started = 1'b0;
    logic [32:0] arch [64];
    logic        m_clear, m_ready;
    int          m_cnt;
    logic [5:0]  m_lat1, m_lat2, e1, e2;
    logic [32:0] exp1, exp2, exp_wd;
    logic        commit, exp_we;
    logic        m0_clear, m0_ready;

    // compare process: every cycle, check outputs then advance the model
    always @(negedge clk) begin
        if (mdl_en) begin
            if (!mdl_started) begin
                for (int i = 0; i < 64; i++) arch[i] = garb[i];
                m_clear = 1'b1; m_ready = 1'b0; m_cnt = 0;
                m_lat1 = 6'd0; m_lat2 = 6'd0; exp1 = 33'd0; exp2 = 33'd0;
                m0_clear = 1'b1; m0_ready = 1'b0;
                mdl_started = 1'b1;
            end
            // ---- checks against the model
            chk("ready", {32'd0, ready}, {32'd0, m_ready});
            if (m_ready) begin
                chk("op1", {op1_grubby, op1}, exp1);
                chk("op2", {op2_grubby, op2}, exp2);
            end else begin
                chk("op1_zero", {op1_grubby, op1}, 33'd0);
                chk("op2_zero", {op2_grubby, op2}, 33'd0);
            end
            exp_we = m_clear ? 1'b1 : (wr_en && (wr_addr != 6'd0));
            chk("rs_we", {32'd0, rs_we}, {32'd0, exp_we});
            if (exp_we) begin
                exp_wd = m_clear ? 33'd0 : {wr_grubby, wr_data};
                chk("rs_wa", {27'd0, rs_wa}, m_clear ? 33'(m_cnt) : {27'd0, wr_addr});
                chk("rs_wd", {rs_wg, rs_wd}, exp_wd);
            end
            e1 = rd_hold ? m_lat1 : rd_addr1;
            e2 = rd_hold ? m_lat2 : rd_addr2;
            chk("rs_ra1", {27'd0, rs_ra1}, {27'd0, e1});
            chk("rs_ra2", {27'd0, rs_ra2}, {27'd0, e2});
            // ---- directed literal expectations
            for (int s = 0; s < 2; s++) begin
                if (dir_en[s]) begin
                    case (dir_sel[s])
                        SEL_OP1: chk("dir_op1", {op1_grubby, op1}, dir_val[s]);
                        SEL_OP2: chk("dir_op2", {op2_grubby, op2}, dir_val[s]);
                        SEL_RA1: chk("dir_ra1", {27'd0, rs_ra1}, dir_val[s]);
                        SEL_WA:  chk("dir_wa", {27'd0, rs_wa}, dir_val[s]);
                        SEL_RDY: chk("dir_ready", {32'd0, ready}, dir_val[s]);
                        default: chk("dir_we", {32'd0, rs_we}, dir_val[s]);
                    endcase
                end
            end
            // ---- CLEAR_ALL=0 instance
            chk("d0_ready", {32'd0, ready0}, {32'd0, m0_ready});
            chk("d0_we", {32'd0, we0}, 33'd1);
            chk("d0_wa", {27'd0, wa0}, m0_clear ? 33'd0 : 33'd9);
            chk("d0_wd", {wg0, wd0}, m0_clear ? 33'd0 : {1'b1, 32'hCAFE0009});
            chk("d0_op", {o1g0, o1_0, o2g0, o2_0} == 66'd0 ? 33'd0 : 33'd1, 33'd0);
            // ---- predict next cycle's operands and advance the model
            commit = !m_clear && wr_en && (wr_addr != 6'd0);
            exp1 = (commit && wr_addr == e1) ? {wr_grubby, wr_data} : arch[e1];
            exp2 = (commit && wr_addr == e2) ? {wr_grubby, wr_data} : arch[e2];
            if (m_clear) arch[m_cnt] = 33'd0;
            else if (commit) arch[wr_addr] = {wr_grubby, wr_data};
            m_lat1 = e1;
            m_lat2 = e2;
            if (rst) begin
                m_clear = 1'b1; m_cnt = 0; m_ready = 1'b0; m_lat1 = 6'd0; m_lat2 = 6'd0;
            end else if (m_clear) begin
                if (m_cnt == 63) begin
                    m_clear = 1'b0; m_ready = 1'b1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            if (rst0) begin
                m0_clear = 1'b1; m0_ready = 1'b0;
            end else if (m0_clear) begin
                m0_clear = 1'b0; m0_ready = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        dir_en[0] = 1'b0;
        dir_en[1] = 1'b0;
    endtask

    task automatic expect_lit(input int slot, input int sel, input logic [32:0] val);
        dir_en[slot]  = 1'b1;
        dir_sel[slot] = sel;
        dir_val[slot] = val;
    endtask

    task automatic drive_wr(input logic en, input logic [5:0] a, input logic [31:0] d, input logic g);
        wr_en = en; wr_addr = a; wr_data = d; wr_grubby = g;
    endtask

    task automatic rand_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(3) == 0)
                drive_wr(1'($urandom), 6'($urandom), $urandom, 1'($urandom));
            else
                drive_wr(1'($urandom), 6'($urandom_range(7)), $urandom, 1'($urandom));
            rd_addr1 = ($urandom_range(3) == 0) ? 6'($urandom) : 6'($urandom_range(7));
            rd_addr2 = ($urandom_range(3) == 0) ? 6'($urandom) : 6'($urandom_range(7));
            rd_hold  = ($urandom_range(3) == 0);
            step();
        end
    endtask

    task automatic sweep_check();
        for (int k = 0; k < 64; k++) begin
            rd_addr1 = 6'($urandom); rd_addr2 = 6'($urandom); rd_hold = 1'($urandom);
            drive_wr(1'($urandom), 6'($urandom), $urandom, 1'($urandom));
            expect_lit(0, SEL_WA, 33'(k));
            expect_lit(1, SEL_RDY, 33'd0);
            step();
        end
        expect_lit(0, SEL_RDY, 33'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) garb[i] = {1'($urandom), $urandom};
        dir_en[0] = 1'b0; dir_en[1] = 1'b0;
        dir_sel[0] = 0; dir_sel[1] = 0; dir_val[0] = 33'd0; dir_val[1] = 33'd0;
        rst = 1'b1; rst0 = 1'b1; fill_en = 1'b1;
        drive_wr(1'b0, 6'd0, 32'd0, 1'b0);
        rd_addr1 = 6'd0; rd_addr2 = 6'd0; rd_hold = 1'b0;
        step();
        fill_en = 1'b0;
        mdl_en = 1'b1;
        step();
        step();
        rst = 1'b0; rst0 = 1'b0;
        sweep_check();                                   // now in first RUN cycle
        // same-cycle write/read of x5 bypasses
        drive_wr(1'b1, 6'd5, 32'hDEADBEEF, 1'b1); rd_addr1 = 6'd5; rd_addr2 = 6'd0; rd_hold = 1'b0;
        step();
        expect_lit(0, SEL_OP1, {1'b1, 32'hDEADBEEF});
        expect_lit(1, SEL_OP2, 33'd0);
        drive_wr(1'b0, 6'd0, 32'd0, 1'b0);
        step();
        expect_lit(0, SEL_OP1, {1'b1, 32'hDEADBEEF});   // from the BRAM now
        // write to x0 is dropped
        drive_wr(1'b1, 6'd0, 32'h12345678, 1'b1); rd_addr1 = 6'd0; rd_addr2 = 6'd0;
        expect_lit(1, SEL_WE, 33'd0);
        step();
        expect_lit(0, SEL_OP1, 33'd0);
        expect_lit(1, SEL_OP2, 33'd0);
        drive_wr(1'b0, 6'd0, 32'd0, 1'b0);
        step();
        expect_lit(0, SEL_OP1, 33'd0);
        // hold: x3 stays selected, write during hold shows up one cycle later
        drive_wr(1'b1, 6'd3, 32'h00000011, 1'b0); rd_addr1 = 6'd3;
        step();
        expect_lit(0, SEL_OP1, 33'h11);
        drive_wr(1'b0, 6'd0, 32'd0, 1'b0); rd_hold = 1'b1; rd_addr1 = 6'd9;
        expect_lit(1, SEL_RA1, 33'd3);
        step();
        expect_lit(0, SEL_OP1, 33'h11);
        drive_wr(1'b1, 6'd3, 32'hA5A5A5A5, 1'b0);
        expect_lit(1, SEL_RA1, 33'd3);
        step();
        expect_lit(0, SEL_OP1, {1'b0, 32'hA5A5A5A5});
        drive_wr(1'b0, 6'd0, 32'd0, 1'b0);
        expect_lit(1, SEL_RA1, 33'd3);
        step();
        expect_lit(0, SEL_OP1, {1'b0, 32'hA5A5A5A5});
        // both ports bypass the same write
        rd_hold = 1'b0; drive_wr(1'b1, 6'd7, 32'h00000055, 1'b0); rd_addr1 = 6'd7; rd_addr2 = 6'd7;
        step();
        expect_lit(0, SEL_OP1, 33'h55);
        expect_lit(1, SEL_OP2, 33'h55);
        drive_wr(1'b0, 6'd0, 32'd0, 1'b0);
        rand_cycles(600);
        // mid-sweep reset at counter 20, plus a reset pulse on the CLEAR_ALL=0 instance
        rst = 1'b1; rst0 = 1'b1;
        step();
        rst = 1'b0; rst0 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            rd_addr1 = 6'($urandom); rd_addr2 = 6'($urandom);
            step();
        end
        expect_lit(0, SEL_WA, 33'd20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sweep_check();
        rand_cycles(400);
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
